// File: rtl/memoria_dados_pkg.sv
// Shared types and default sizing for the data-memory controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package memoria_dados_pkg;

  // ST_CLEAR is the reset state: the array is swept to zero before any request is taken.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed storage with a lane-masked synchronous write port and a registered read port.
// Latency: write lands on the edge it is presented; read data appears one cycle after re.
// Backpressure: none; both ports take one operation per cycle.
//
// Ports: clock, reset (clears only the read register; the storage itself is never reset),
//        we/waddr/wmask/wdata write port, re/raddr read port, rdata registered read data.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int LANES  = 2,
  parameter int LANE_W = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [LANES-1:0]        wmask,
  input  logic [LANES*LANE_W-1:0] wdata,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       raddr,
  output logic [LANES*LANE_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [LANES*LANE_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Read register holds its value between reads so the response data stays stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/memoria_dados_ctl.sv
// Data-memory controller: zero-sweeps the array after reset / clear_start, then serves byte-masked reads and writes.
// Latency: read response one cycle after acceptance; writes visible to a read accepted the following cycle.
// Backpressure: req_ready low during a sweep and while clear_start is high; responses cannot be stalled.
//
// Ports: clock, reset (async, active-high); req_valid/req_ready/req_we/req_addr/req_wdata/req_wmask request;
//        rsp_valid/rsp_rdata response; clear_start/busy sweep control.
// Build option MEMORIA_DADOS_PARITY_EN: adds one even-parity bit per lane, input par_inject and output par_err.
module memoria_dados_ctl
  import memoria_dados_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  input  logic [DATA_W/8-1:0]    req_wmask,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  input  logic                   clear_start,
  output logic                   busy
`ifdef MEMORIA_DADOS_PARITY_EN
  ,
  input  logic                   par_inject,
  output logic                   par_err
`endif
);

  localparam int LANES = DATA_W / 8;
`ifdef MEMORIA_DADOS_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int MEM_W = LANES * LANE_W;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic                in_clear;
  logic                accept;
  logic                rd_en;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [LANES-1:0]    wr_mask;
  logic [DATA_W-1:0]   wr_bytes;
  logic [MEM_W-1:0]    wr_word;
  logic [MEM_W-1:0]    rd_word;

  assign in_clear  = (state_q == ST_CLEAR);
  assign busy      = in_clear;
  assign req_ready = (state_q == ST_IDLE) & ~clear_start;
  assign accept    = req_valid & req_ready;
  assign rd_en     = accept & ~req_we;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      sweep_q   <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      rsp_valid <= rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      ST_CLEAR: begin
        // clear_start is ignored here; the sweep always runs to the last word.
        sweep_d = sweep_q + ADDR_W'(1);
        if (sweep_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear_start) begin
          state_d = ST_CLEAR;
          sweep_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // The sweep owns the write port while clearing; requests are blocked then, so no arbitration is needed.
  always_comb begin
    wr_en    = in_clear | (accept & req_we);
    wr_addr  = in_clear ? sweep_q : req_addr;
    wr_mask  = in_clear ? {LANES{1'b1}} : req_wmask;
    wr_bytes = in_clear ? '0 : req_wdata;
    wr_word  = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_word[i*LANE_W +: 8] = wr_bytes[i*8 +: 8];
`ifdef MEMORIA_DADOS_PARITY_EN
      // Even parity; injection only corrupts request writes so the sweep always leaves clean parity.
      wr_word[i*LANE_W + 8] = (^wr_bytes[i*8 +: 8]) ^ (par_inject & ~in_clear);
`endif
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .LANES  (LANES),
    .LANE_W (LANE_W)
  ) u_array (
    .clock (clock),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_addr),
    .wmask (wr_mask),
    .wdata (wr_word),
    .re    (rd_en),
    .raddr (req_addr),
    .rdata (rd_word)
  );

  always_comb begin
    rsp_rdata = '0;
    for (int i = 0; i < LANES; i++) rsp_rdata[i*8 +: 8] = rd_word[i*LANE_W +: 8];
  end

`ifdef MEMORIA_DADOS_PARITY_EN
  logic [LANES-1:0] lane_err;

  always_comb begin
    lane_err = '0;
    for (int i = 0; i < LANES; i++) lane_err[i] = ^rd_word[i*LANE_W +: LANE_W];
  end

  // Qualified by rsp_valid so it pulses with the response and is 0 out of reset.
  assign par_err = rsp_valid & (|lane_err);
`endif

endmodule

// File: tb/tb_memoria_dados_ctl.sv
module tb_memoria_dados_ctl;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [1:0]    req_wmask = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          clear_start = 1'b0;
  logic          busy;
`ifdef MEMORIA_DADOS_PARITY_EN
  logic          par_inject = 1'b0;
  logic          par_err;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  memoria_dados_ctl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .clear_start (clear_start),
    .busy        (busy)
`ifdef MEMORIA_DADOS_PARITY_EN
    ,
    .par_inject  (par_inject),
    .par_err     (par_err)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_wmask = m;
    @(negedge clock);
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [15:0] exp, input string nm);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge clock);
    req_valid = 1'b0;
    chk({nm, "_vld"}, {31'd0, rsp_valid}, 32'd1);
    chk(nm, {16'd0, rsp_rdata}, {16'd0, exp});
  endtask

  // Counts cycles until busy drops (bounded); optionally pokes clear_start once mid-sweep.
  task automatic count_busy(output int cnt, output logic saw_rsp, input int poke_at);
    cnt = 0;
    saw_rsp = 1'b0;
    while (busy === 1'b1 && cnt < 100) begin
      clear_start = (cnt == poke_at);
      @(negedge clock);
      cnt++;
      if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
    end
    clear_start = 1'b0;
  endtask

  initial begin
    int   c;
    logic s;

    vecs[0]  = '{1'b1, 4'h3, 16'hABCD, 2'b11, 16'h0000};
    vecs[1]  = '{1'b0, 4'h3, 16'h0000, 2'b00, 16'hABCD};
    vecs[2]  = '{1'b1, 4'h3, 16'h1234, 2'b01, 16'h0000};
    vecs[3]  = '{1'b0, 4'h3, 16'h0000, 2'b00, 16'hAB34};
    vecs[4]  = '{1'b1, 4'h3, 16'hFFFF, 2'b00, 16'h0000};
    vecs[5]  = '{1'b0, 4'h3, 16'h0000, 2'b00, 16'hAB34};
    vecs[6]  = '{1'b1, 4'h5, 16'h5A5A, 2'b10, 16'h0000};
    vecs[7]  = '{1'b0, 4'h5, 16'h0000, 2'b00, 16'h5A00};
    vecs[8]  = '{1'b0, 4'hF, 16'h0000, 2'b00, 16'h0000};
    vecs[9]  = '{1'b1, 4'hF, 16'hBEEF, 2'b11, 16'h0000};
    vecs[10] = '{1'b0, 4'hF, 16'h0000, 2'b00, 16'hBEEF};
    vecs[11] = '{1'b0, 4'h3, 16'h0000, 2'b00, 16'hAB34};
    vecs[12] = '{1'b1, 4'h0, 16'h00C3, 2'b01, 16'h0000};
    vecs[13] = '{1'b0, 4'h0, 16'h0000, 2'b00, 16'h00C3};

    // Reset held: sweep state, no response.
    #2 reset = 1'b1;
    #20;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    count_busy(c, s, -1);
    chk("init_sweep_cycles", c, 32'd16);
    chk("init_ready", {31'd0, req_ready}, 32'd1);
    do_read(4'hF, 16'h0000, "init_rd_f");

    // Back-to-back request vectors, one per cycle.
    for (int k = 0; k < 14; k++) begin
      req_valid = 1'b1; req_we = vecs[k].we; req_addr = vecs[k].addr;
      req_wdata = vecs[k].wdata; req_wmask = vecs[k].wmask;
      @(negedge clock);
      if (vecs[k].we) begin
        chk($sformatf("vec%0d_wr_no_rsp", k), {31'd0, rsp_valid}, 32'd0);
      end else begin
        chk($sformatf("vec%0d_vld", k), {31'd0, rsp_valid}, 32'd1);
        chk($sformatf("vec%0d_data", k), {16'd0, rsp_rdata}, {16'd0, vecs[k].exp});
      end
    end
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge clock);
    chk("hold_vld", {31'd0, rsp_valid}, 32'd0);
    chk("hold_data", {16'd0, rsp_rdata}, 32'h00C3);

`ifdef MEMORIA_DADOS_PARITY_EN
    par_inject = 1'b1;
    do_write(4'h5, 16'h1111, 2'b11);
    par_inject = 1'b0;
    do_read(4'h5, 16'h1111, "par_rd5");
    chk("par_err_5", {31'd0, par_err}, 32'd1);
    do_read(4'h6, 16'h0000, "par_rd6");
    chk("par_err_6", {31'd0, par_err}, 32'd0);
`endif

    // Read response while clear_start arrives, then clear_start with a competing read.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h3;
    @(negedge clock);
    chk("pre_clr_vld", {31'd0, rsp_valid}, 32'd1);
    chk("pre_clr_data", {16'd0, rsp_rdata}, 32'hAB34);
    clear_start = 1'b1;
    #1;
    chk("clr_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    req_valid = 1'b0; clear_start = 1'b0;
    chk("clr_not_accepted", {31'd0, rsp_valid}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd1);
    count_busy(c, s, 5);
    chk("clr_sweep_cycles", c, 32'd16);
    chk("clr_no_rsp", {31'd0, s}, 32'd0);
    for (int a = 0; a < 16; a++) do_read(a[3:0], 16'h0000, $sformatf("clr_rd%0d", a));

    // Reset during an in-flight read discards the response.
    do_write(4'h9, 16'h9999, 2'b11);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h9;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("midreq_rsp_dropped", {31'd0, rsp_valid}, 32'd0);
    chk("midreq_rdata_zero", {16'd0, rsp_rdata}, 32'd0);
    @(negedge clock);
    req_valid = 1'b0; reset = 1'b0;
    count_busy(c, s, -1);
    chk("midreq_sweep_cycles", c, 32'd16);
    chk("midreq_no_rsp", {31'd0, s}, 32'd0);

    // Reset at sweep address 7 restarts a full sweep.
    do_write(4'h9, 16'h9999, 2'b11);
    do_write(4'h2, 16'h2222, 2'b11);
    @(negedge clock);
    clear_start = 1'b1;
    @(negedge clock);
    clear_start = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("sw7_rst_busy", {31'd0, busy}, 32'd1);
    chk("sw7_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    count_busy(c, s, -1);
    chk("sw7_sweep_cycles", c, 32'd16);
    chk("sw7_no_rsp", {31'd0, s}, 32'd0);
    do_read(4'h9, 16'h0000, "sw7_rd9");
    do_read(4'h2, 16'h0000, "sw7_rd2");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
